// File: rtl/morphle_vector_checker.sv
// morphle_vector_checker
//   Vector player/checker for Morphle Logic cells. Vectors are written into an
//   internal memory, then replayed one at a time: the stimulus is driven and
//   held, the DUT outputs are compared after WAIT_CYC settle cycles, and
//   failures are counted. Each vector carries a per-bit don't-care mask and a
//   last flag. The first failing vector's index and outputs are captured.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   load_we/addr/data vector memory write port ({last, stim, expect, mask});
//                     ignored while a run is in progress
//   start             pulse; begins a run at vector 0 (from idle or done)
//   stim              registered stimulus to the cell under test
//   dut_out           outputs of the cell under test
//   busy, done        run in progress / run finished (held until restart)
//   wrapped           run ended at the last address without a last flag
//   error_count       failing checked vectors, saturating
//   vector_count      vectors applied in this run
//   first_err_*       capture of the first failing vector
module morphle_vector_checker #(
  parameter int IN_W     = 15,
  parameter int OUT_W    = 11,
  parameter int ADDR_W   = 10,
  parameter int SKIP     = 7,
  parameter int WAIT_CYC = 1,
  parameter int ERR_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_we,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [1+IN_W+2*OUT_W-1:0] load_data,
  input  logic                      start,
  output logic [IN_W-1:0]           stim,
  input  logic [OUT_W-1:0]          dut_out,
  output logic                      busy,
  output logic                      done,
  output logic                      wrapped,
  output logic [ERR_W-1:0]          error_count,
  output logic [ADDR_W:0]           vector_count,
  output logic                      first_err_valid,
  output logic [ADDR_W-1:0]         first_err_index,
  output logic [OUT_W-1:0]          first_err_got
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int WCW   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int SKW   = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  typedef struct packed {
    logic             last;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] exp_bits;
    logic [OUT_W-1:0] mask;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  // Vector memory: never reset, so contents survive a reset.
  vec_t mem_q [DEPTH];
  vec_t rd_d, rd_q;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [SKW-1:0]    skip_q, skip_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic [OUT_W-1:0]  exp_q, exp_d;
  logic [OUT_W-1:0]  mask_q, mask_d;
  logic              last_q, last_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W:0]   vcnt_q, vcnt_d;
  logic              wrapped_q, wrapped_d;
  logic              fe_valid_q, fe_valid_d;
  logic [ADDR_W-1:0] fe_idx_q, fe_idx_d;
  logic [OUT_W-1:0]  fe_got_q, fe_got_d;
  logic              busy_w, fail_w;

  assign busy_w = (state_q == S_FETCH) || (state_q == S_APPLY) ||
                  (state_q == S_SETTLE) || (state_q == S_CHECK);

  // Read address is always idx; it is stable from FETCH through CHECK, so the
  // registered read data is valid in APPLY.
  always_comb begin
    rd_d = mem_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (load_we && !busy_w) mem_q[load_addr] <= vec_t'(load_data);
    rd_q <= rd_d;
  end

  // skip_q counts down the leading unchecked vectors; checking is enabled once
  // it reaches zero.
  assign fail_w = (skip_q == '0) && (((dut_out ^ exp_q) & ~mask_q) != '0);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    skip_d     = skip_q;
    stim_d     = stim_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    last_d     = last_q;
    err_d      = err_q;
    vcnt_d     = vcnt_q;
    wrapped_d  = wrapped_q;
    fe_valid_d = fe_valid_q;
    fe_idx_d   = fe_idx_q;
    fe_got_d   = fe_got_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          skip_d     = SKW'(SKIP);
          err_d      = '0;
          vcnt_d     = '0;
          wrapped_d  = 1'b0;
          fe_valid_d = 1'b0;
          fe_idx_d   = '0;
          fe_got_d   = '0;
        end
      end
      S_FETCH: state_d = S_APPLY;
      S_APPLY: begin
        stim_d  = rd_q.stim;
        exp_d   = rd_q.exp_bits;
        mask_d  = rd_q.mask;
        last_d  = rd_q.last;
        vcnt_d  = vcnt_q + (ADDR_W+1)'(1);
        wait_d  = '0;
        state_d = (WAIT_CYC == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (wait_q == WCW'(WAIT_CYC - 1)) state_d = S_CHECK;
        else                              wait_d  = wait_q + WCW'(1);
      end
      S_CHECK: begin
        if (skip_q != '0) skip_d = skip_q - SKW'(1);
        if (fail_w) begin
          if (~&err_q) err_d = err_q + ERR_W'(1);
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_idx_d   = idx_q;
            fe_got_d   = dut_out;
          end
        end
        if (last_q) begin
          state_d = S_DONE;
        end else if (&idx_q) begin
          state_d   = S_DONE;
          wrapped_d = 1'b1;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      skip_q     <= '0;
      stim_q     <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= '0;
      vcnt_q     <= '0;
      wrapped_q  <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_got_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      skip_q     <= skip_d;
      stim_q     <= stim_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      err_q      <= err_d;
      vcnt_q     <= vcnt_d;
      wrapped_q  <= wrapped_d;
      fe_valid_q <= fe_valid_d;
      fe_idx_q   <= fe_idx_d;
      fe_got_q   <= fe_got_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = busy_w;
  assign done            = (state_q == S_DONE);
  assign wrapped         = wrapped_q;
  assign error_count     = err_q;
  assign vector_count    = vcnt_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_index = fe_idx_q;
  assign first_err_got   = fe_got_q;

endmodule

// File: tb/tb_morphle_vector_checker.sv
// Bench: three checker instances with different parameters share one load bus
// and start strobe; each loops its stimulus back as dut_out. Results are
// compared to hand-written expectations and to a vector-list reference model.
module tb_morphle_vector_checker;
  localparam int IN_W  = 15;
  localparam int OUT_W = 11;
  localparam int VW    = 1 + IN_W + 2*OUT_W;

  logic clk = 1'b0;
  logic reset, load_we, start;
  logic [3:0]    load_addr;
  logic [VW-1:0] load_data;
  always #5 clk = ~clk;

  // u0: 16 deep, SKIP 0, WAIT 1 | u1: 16 deep, SKIP 7, WAIT 0 | u2: 8 deep, WAIT 2, ERR_W 2
  logic [IN_W-1:0] stim0, stim1, stim2;
  logic busy0, busy1, busy2, done0, done1, done2, wr0, wr1, wr2, fv0, fv1, fv2;
  logic [15:0] err0, err1;
  logic [1:0]  err2;
  logic [4:0]  vc0, vc1;
  logic [3:0]  vc2;
  logic [3:0]  fidx0, fidx1;
  logic [2:0]  fidx2;
  logic [OUT_W-1:0] fgot0, fgot1, fgot2;

  morphle_vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(4), .SKIP(0), .WAIT_CYC(1), .ERR_W(16)) u0 (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stim(stim0), .dut_out(stim0[OUT_W-1:0]), .busy(busy0), .done(done0),
    .wrapped(wr0), .error_count(err0), .vector_count(vc0), .first_err_valid(fv0),
    .first_err_index(fidx0), .first_err_got(fgot0));

  morphle_vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(4), .SKIP(7), .WAIT_CYC(0), .ERR_W(16)) u1 (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stim(stim1), .dut_out(stim1[OUT_W-1:0]), .busy(busy1), .done(done1),
    .wrapped(wr1), .error_count(err1), .vector_count(vc1), .first_err_valid(fv1),
    .first_err_index(fidx1), .first_err_got(fgot1));

  morphle_vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(3), .SKIP(0), .WAIT_CYC(2), .ERR_W(2)) u2 (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr[2:0]), .load_data(load_data),
    .start(start), .stim(stim2), .dut_out(stim2[OUT_W-1:0]), .busy(busy2), .done(done2),
    .wrapped(wr2), .error_count(err2), .vector_count(vc2), .first_err_valid(fv2),
    .first_err_index(fidx2), .first_err_got(fgot2));

  typedef struct { int vc, err, fv, fidx, fgot, wr, stim, cyc; } res_t;

  // Directed rows; fidx -1 means no failure expected. u2 sees vectors 8..15
  // because 16 ascending writes alias into its 8 entries.
  typedef struct {
    int last_at, f_lo, f_hi, mask_at;
    int e0_err, e0_vc, e0_fidx, e0_wr;
    int e1_err, e1_vc, e1_fidx, e1_wr;
    int e2_err, e2_vc, e2_wr;
  } dir_t;

  int ncmp = 0, nerr = 0;
  logic [VW-1:0] img [16];
  logic [VW-1:0] img8 [16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input bit last, input logic [IN_W-1:0] s,
                                          input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
    return {last, s, e, m};
  endfunction

  // Reference: walk the vector list, apply the skip/mask/last/wrap rules.
  function automatic res_t model(input logic [VW-1:0] im [16], input int depth, input int skip,
                                 input int errw, input int waitc);
    res_t r;
    int maxe;
    logic [IN_W-1:0] s;
    logic [OUT_W-1:0] e, m, got;
    r = '{default:0};
    maxe = (1 << errw) - 1;
    for (int i = 0; i < depth; i++) begin
      s   = im[i][VW-2 -: IN_W];
      e   = im[i][2*OUT_W-1 -: OUT_W];
      m   = im[i][OUT_W-1:0];
      got = s[OUT_W-1:0];
      r.vc++;
      r.stim = int'(s);
      if (i >= skip && ((got ^ e) & ~m) != '0) begin
        if (r.err < maxe) r.err++;
        if (r.fv == 0) begin r.fv = 1; r.fidx = i; r.fgot = int'(got); end
      end
      if (im[i][VW-1]) break;
      if (i == depth - 1) r.wr = 1;
    end
    r.cyc = r.vc * (3 + waitc);
    return r;
  endfunction

  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 4'(i); load_data = img[i];
      tick();
    end
    load_we = 1'b0;
    for (int j = 0; j < 16; j++) img8[j] = img[(j % 8) + 8];
  endtask

  // Pulse start and wait for all three to finish; optionally try a write and
  // a second start while busy, both of which must be ignored.
  task automatic run(input bit disturb, output res_t a0, output res_t a1, output res_t a2);
    int c;
    bit d0, d1, d2;
    a0 = '{default:0}; a1 = '{default:0}; a2 = '{default:0};
    a0.cyc = -1; a1.cyc = -1; a2.cyc = -1;
    d0 = 0; d1 = 0; d2 = 0; c = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", int'(busy0), 1);
    chk("done_cleared_on_start", int'(done0), 0);
    while (!(d0 && d1 && d2) && c < 3000) begin
      if (disturb && c == 3) begin
        load_we = 1'b1; load_addr = 4'd0; load_data = mkvec(1'b1, 15'h7fff, 11'h000, 11'h000);
        start = 1'b1;
      end
      tick();
      load_we = 1'b0; start = 1'b0;
      c++;
      if (done0 && !d0) begin d0 = 1; a0.cyc = c; end
      if (done1 && !d1) begin d1 = 1; a1.cyc = c; end
      if (done2 && !d2) begin d2 = 1; a2.cyc = c; end
    end
    ncmp++;
    if (!(d0 && d1 && d2)) begin
      nerr++;
      $display("FAIL run_timeout: done=%0d%0d%0d required 111", d0, d1, d2);
    end
    a0.vc = int'(vc0); a0.err = int'(err0); a0.fv = int'(fv0); a0.fidx = int'(fidx0);
    a0.fgot = int'(fgot0); a0.wr = int'(wr0); a0.stim = int'(stim0);
    a1.vc = int'(vc1); a1.err = int'(err1); a1.fv = int'(fv1); a1.fidx = int'(fidx1);
    a1.fgot = int'(fgot1); a1.wr = int'(wr1); a1.stim = int'(stim1);
    a2.vc = int'(vc2); a2.err = int'(err2); a2.fv = int'(fv2); a2.fidx = int'(fidx2);
    a2.fgot = int'(fgot2); a2.wr = int'(wr2); a2.stim = int'(stim2);
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, "_vc"}, a.vc, e.vc);
    chk({tag, "_err"}, a.err, e.err);
    chk({tag, "_fv"}, a.fv, e.fv);
    chk({tag, "_wrapped"}, a.wr, e.wr);
    chk({tag, "_stim"}, a.stim, e.stim);
    chk({tag, "_cycles"}, a.cyc, e.cyc);
    if (e.fv != 0) begin
      chk({tag, "_fidx"}, a.fidx, e.fidx);
      chk({tag, "_fgot"}, a.fgot, e.fgot);
    end
  endtask

  task automatic cmp_all(input string tag, input res_t a0, input res_t a1, input res_t a2);
    cmp_res({tag, "_u0"}, a0, model(img, 16, 0, 16, 1));
    cmp_res({tag, "_u1"}, a1, model(img, 16, 7, 16, 0));
    cmp_res({tag, "_u2"}, a2, model(img8, 8, 0, 2, 2));
  endtask

  task automatic build_dir(input dir_t t);
    logic [IN_W-1:0] s;
    logic [OUT_W-1:0] e;
    for (int i = 0; i < 16; i++) begin
      s = IN_W'((i * 2579 + 113) & 32'h7fff);
      e = s[OUT_W-1:0];
      if (i >= t.f_lo && i <= t.f_hi) e[0] = ~e[0];
      img[i] = mkvec(i == t.last_at, s, e, (i == t.mask_at) ? 11'h001 : 11'h000);
    end
  endtask

  dir_t tbl [5];
  res_t a0, a1, a2, p0, p1, p2;

  initial begin
    //            last f_lo f_hi mask | u0 err vc fidx wr | u1 err vc fidx wr | u2 err vc wr
    tbl[0] = '{ 2, 1, 0, -1,   0, 3, -1, 0,   0, 3, -1, 0,   0, 8, 1};  // loopback
    tbl[1] = '{ 2, 2, 2, -1,   1, 3,  2, 0,   0, 3, -1, 0,   0, 8, 1};  // single fault
    tbl[2] = '{ 2, 2, 2,  2,   0, 3, -1, 0,   0, 3, -1, 0,   0, 8, 1};  // masked fault
    tbl[3] = '{ 8, 0, 7, -1,   8, 9,  0, 0,   1, 9,  7, 0,   0, 1, 0};  // skip window
    tbl[4] = '{-1, 0, 15, -1, 16, 16, 0, 1,   9, 16, 7, 1,   3, 8, 1};  // wrap + saturate

    reset = 1'b1; start = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_stim", int'(stim0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_wrapped", int'(wr0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_vc", int'(vc0), 0);
    chk("rst_fv", int'(fv0), 0);
    chk("rst_fidx_fgot", int'(fidx0) + int'(fgot0), 0);
    chk("rst_u1u2_busy", int'(busy1) + int'(busy2) + int'(done2), 0);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    chk("start_with_reset_busy", int'(busy0), 0);
    tick();
    chk("start_with_reset_busy_later", int'(busy0) + int'(busy2), 0);

    for (int r = 0; r < 5; r++) begin
      build_dir(tbl[r]);
      load_all();
      run(1'b0, a0, a1, a2);
      chk($sformatf("dir%0d_u0_err", r), a0.err, tbl[r].e0_err);
      chk($sformatf("dir%0d_u0_vc", r), a0.vc, tbl[r].e0_vc);
      chk($sformatf("dir%0d_u0_wr", r), a0.wr, tbl[r].e0_wr);
      chk($sformatf("dir%0d_u0_fv", r), a0.fv, int'(tbl[r].e0_fidx >= 0));
      if (tbl[r].e0_fidx >= 0) chk($sformatf("dir%0d_u0_fidx", r), a0.fidx, tbl[r].e0_fidx);
      chk($sformatf("dir%0d_u0_cycles", r), a0.cyc, tbl[r].e0_vc * 4);
      chk($sformatf("dir%0d_u1_err", r), a1.err, tbl[r].e1_err);
      chk($sformatf("dir%0d_u1_vc", r), a1.vc, tbl[r].e1_vc);
      chk($sformatf("dir%0d_u1_wr", r), a1.wr, tbl[r].e1_wr);
      if (tbl[r].e1_fidx >= 0) chk($sformatf("dir%0d_u1_fidx", r), a1.fidx, tbl[r].e1_fidx);
      chk($sformatf("dir%0d_u2_err", r), a2.err, tbl[r].e2_err);
      chk($sformatf("dir%0d_u2_vc", r), a2.vc, tbl[r].e2_vc);
      chk($sformatf("dir%0d_u2_wr", r), a2.wr, tbl[r].e2_wr);
      cmp_all($sformatf("dir%0d", r), a0, a1, a2);
    end
    // Loopback first_err_got for the single-fault row: stim of vector 2, low bits.
    build_dir(tbl[1]);
    load_all();
    run(1'b0, a0, a1, a2);
    chk("fault_fgot", a0.fgot, (2 * 2579 + 113) & 11'h7ff);

    // Reset while vector 4 is applied.
    build_dir(tbl[4]);
    load_all();
    begin
      int c;
      c = 0;
      start = 1'b1; tick(); start = 1'b0;
      while (int'(vc0) != 5 && c < 200) begin tick(); c++; end
      chk("midrun_reached_vec4", int'(vc0), 5);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("midrun_busy", int'(busy0) + int'(busy1) + int'(busy2), 0);
      chk("midrun_stim", int'(stim0), 0);
      chk("midrun_err", int'(err0), 0);
      chk("midrun_vc", int'(vc0), 0);
      chk("midrun_fv", int'(fv0), 0);
      chk("midrun_done", int'(done0), 0);
    end

    // Write and start while busy are ignored; a rerun gives identical results.
    build_dir(tbl[3]);
    load_all();
    run(1'b1, p0, p1, p2);
    cmp_all("busy_write", p0, p1, p2);
    run(1'b0, a0, a1, a2);
    cmp_all("rerun", a0, a1, a2);
    chk("rerun_same_err", a1.err, p1.err);

    // Random vector lists against the reference model.
    for (int it = 0; it < 8; it++) begin
      logic [IN_W-1:0] s;
      logic [OUT_W-1:0] e, m;
      for (int i = 0; i < 16; i++) begin
        s = IN_W'($urandom);
        e = s[OUT_W-1:0];
        if ($urandom_range(0, 2) == 0) e = e ^ OUT_W'($urandom);
        m = OUT_W'($urandom & $urandom & $urandom);
        img[i] = mkvec($urandom_range(0, 6) == 0, s, e, m);
      end
      load_all();
      run(1'b0, a0, a1, a2);
      cmp_all($sformatf("rand%0d", it), a0, a1, a2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
